// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath slice: register-file geometry and ALU op encodings.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  function automatic logic [DATA_W-1:0] alu_eval(input alu_op_e op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] diff;
    diff = a - b;
    case (op)
      ALU_AND: alu_eval = a & b;
      ALU_OR:  alu_eval = a | b;
      ALU_ADD: alu_eval = a + b;
      ALU_SUB: alu_eval = diff;
      ALU_SLT: alu_eval = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_eval = '0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// Two-read / one-write register file with hardwired zero register and async clear.
module reg_file #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);
  import mips_pkg::*;

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [NREG-1:0][DATA_W-1:0] regs_q;
  logic [NREG-1:0][DATA_W-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && (wa != ZERO_A)) begin
      regs_d[wa] = wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: wd is derived from rd1/rd2 through the ALU, so forwarding would loop.
  always_comb begin
    rd1 = (ra1 == ZERO_A) ? '0 : regs_q[ra1];
    rd2 = (ra2 == ZERO_A) ? '0 : regs_q[ra2];
  end

`ifndef SYNTHESIS
  a_zero_rd1: assert property (@(posedge clk) (ra1 == ZERO_A) |-> (rd1 == '0));
  a_zero_rd2: assert property (@(posedge clk) (ra2 == ZERO_A) |-> (rd2 == '0));
  a_hold:     assert property (@(posedge clk) disable iff (!rst_n) !we |-> (regs_d == regs_q));
`endif

endmodule
